// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the
// multi-cycle fetch/exec sequencer.
package cycle_sequencer_pkg;

  localparam int ADDR_W = 19;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_HALT = 5'b11111;
  localparam logic [OP_W-1:0] OP_CALL = 5'b01110;
  localparam logic [OP_W-1:0] OP_RET  = 5'b10001;

  // One-hot state bit positions
  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_EXEC   = 2;
  localparam int S_MEM    = 3;
  localparam int S_HALT   = 4;

  typedef enum logic [4:0] {
    FETCH  = 5'b00001,
    DECODE = 5'b00010,
    EXEC   = 5'b00100,
    MEM    = 5'b01000,
    HALT   = 5'b10000
  } state_t;

  function automatic logic [ADDR_W-1:0] inc_pc(
    input logic [ADDR_W-1:0] a
  );
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cycle_sequencer_ret_stack.sv
// Return-address stack; pointer is reset,
// storage is not.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  assign widx  = sp[IW-1:0];
  assign ridx  = sp[IW-1:0] - IW'(1);
  assign full  = (sp == PW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[ridx];

  // Stack pointer: count of valid entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

  // Entry storage, written on push only
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[widx] <= din;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Fetch/decode/exec/mem sequencer with pc
// update and return-stack call/return.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int STK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_regwrite,
  input  logic              dec_memwrite,
  input  logic              dec_resultsrc,
  input  logic [1:0]        dec_jump,
  input  logic              dec_push,
  input  logic              dec_pop,
  input  logic [ADDR_W-1:0] target,
  output logic              regwrite_en,
  output logic              dmem_req,
  output logic              memwrite_en,
  input  logic              dmem_ack,
  output logic              halted,
  output logic              stk_ovf,
  output logic              stk_unf
);

  state_t            state;
  logic              in_fetch;
  logic              in_exec;
  logic              in_mem;
  logic              op_halt;
  logic              mem_op;
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic [ADDR_W-1:0] pc_inc;

  assign in_fetch = state[S_FETCH];
  assign in_exec  = state[S_EXEC];
  assign in_mem   = state[S_MEM];

  assign op_halt = (ir[ADDR_W-1 -: OP_W] == OP_HALT);
  assign mem_op  = dec_memwrite | dec_resultsrc;
  assign pc_inc  = inc_pc(pc);

  assign stk_push = in_exec & ~op_halt & ~mem_op
                  & dec_push & ~stk_full;
  assign stk_pop  = in_exec & ~op_halt & ~mem_op
                  & ~dec_push & dec_pop & ~stk_empty;

  // Strobes are single state bits gated by
  // the stable decode of the latched ir
  assign imem_req    = in_fetch & rst_n;
  assign imem_addr   = pc;
  assign dmem_req    = in_mem;
  assign memwrite_en = in_mem & dec_memwrite;
  assign halted      = state[S_HALT];
  assign regwrite_en =
      (in_exec & dec_regwrite & ~dec_resultsrc)
    | (in_mem & dmem_ack & dec_resultsrc
       & ~dec_memwrite);

  ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (ADDR_W)
  ) u_stk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Sequencer FSM with pc, ir and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          if (op_halt) begin
            state <= HALT;
          end else if (mem_op) begin
            state <= MEM;
          end else if (dec_push) begin
            if (stk_full) begin
              stk_ovf <= 1'b1;
              state   <= HALT;
            end else begin
              pc    <= target;
              state <= FETCH;
            end
          end else if (dec_pop) begin
            if (stk_empty) begin
              stk_unf <= 1'b1;
              state   <= HALT;
            end else begin
              pc    <= stk_top;
              state <= FETCH;
            end
          end else begin
            if (dec_jump == 2'b01) begin
              pc <= target;
            end else begin
              pc <= pc_inc;
            end
            state <= FETCH;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
